// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register for the uDLX core.
// Registers the decoded instruction for the execute stage and detects
// load-use hazards against the load currently in EX. On a hazard it loads a
// bubble and asks fetch/decode to hold for one cycle. A saturating counter
// records how many cycles were lost to load-use stalls.
module id_ex_hazard_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_data_a,
    input  logic [DATA_WIDTH-1:0]     id_data_b,
    input  logic [REG_ADDR_WIDTH-1:0] id_addr_a,
    input  logic [REG_ADDR_WIDTH-1:0] id_addr_b,
    input  logic                      id_rd_a_ena,
    input  logic                      id_rd_b_ena,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_reg_addr,
    input  logic                      id_reg_wr_ena,
    input  logic                      id_mem_rd_ena,
    input  logic                      id_mem_wr_ena,
    input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    input  logic                      flush,
    input  logic                      pipe_stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_data_alu_a,
    output logic [DATA_WIDTH-1:0]     ex_data_alu_b,
    output logic [REG_ADDR_WIDTH-1:0] ex_addr_alu_a,
    output logic [REG_ADDR_WIDTH-1:0] ex_addr_alu_b,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_reg_addr,
    output logic                      ex_reg_wr_ena,
    output logic                      ex_mem_rd_ena,
    output logic                      ex_mem_wr_ena,
    output logic [ALU_OP_WIDTH-1:0]   ex_alu_op,
    output logic                      id_stall,
    output logic [CNT_WIDTH-1:0]      lu_stall_cnt
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

    logic src_a_hit_s;
    logic src_b_hit_s;
    logic ex_is_load_s;
    logic lu_hazard_s;
    logic load_bubble_s;
    logic count_stall_s;

    // Load-use detection: the instruction in decode reads the register the EX load writes.
    always_comb begin
        src_a_hit_s  = id_rd_a_ena & (id_addr_a == ex_reg_addr);
        src_b_hit_s  = id_rd_b_ena & (id_addr_b == ex_reg_addr);
        ex_is_load_s = ex_valid & ex_mem_rd_ena & ex_reg_wr_ena & (ex_reg_addr != REG_ZERO);
        lu_hazard_s  = id_valid & ex_is_load_s & (src_a_hit_s | src_b_hit_s);
    end

    // Per-cycle action decode: global stall beats flush beats load-use hazard.
    always_comb begin
        load_bubble_s = 1'b0;
        count_stall_s = 1'b0;
        id_stall      = 1'b0;
        if (!rst_n) begin
            id_stall = 1'b0;
        end else if (pipe_stall) begin
            id_stall = 1'b1;
        end else if (flush) begin
            load_bubble_s = 1'b1;
        end else if (lu_hazard_s) begin
            load_bubble_s = 1'b1;
            count_stall_s = 1'b1;
            id_stall      = 1'b1;
        end else begin
            // An empty decode slot enters EX as a bubble as well.
            load_bubble_s = ~id_valid;
        end
    end

    // EX stage register: hold on global stall, bubble or capture otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_data_alu_a <= {DATA_WIDTH{1'b0}};
            ex_data_alu_b <= {DATA_WIDTH{1'b0}};
            ex_addr_alu_a <= REG_ZERO;
            ex_addr_alu_b <= REG_ZERO;
            ex_imm        <= {DATA_WIDTH{1'b0}};
            ex_reg_addr   <= REG_ZERO;
            ex_reg_wr_ena <= 1'b0;
            ex_mem_rd_ena <= 1'b0;
            ex_mem_wr_ena <= 1'b0;
            ex_alu_op     <= {ALU_OP_WIDTH{1'b0}};
        end else if (pipe_stall) begin
            ex_valid      <= ex_valid;
            ex_data_alu_a <= ex_data_alu_a;
            ex_data_alu_b <= ex_data_alu_b;
            ex_addr_alu_a <= ex_addr_alu_a;
            ex_addr_alu_b <= ex_addr_alu_b;
            ex_imm        <= ex_imm;
            ex_reg_addr   <= ex_reg_addr;
            ex_reg_wr_ena <= ex_reg_wr_ena;
            ex_mem_rd_ena <= ex_mem_rd_ena;
            ex_mem_wr_ena <= ex_mem_wr_ena;
            ex_alu_op     <= ex_alu_op;
        end else if (load_bubble_s) begin
            ex_valid      <= 1'b0;
            ex_data_alu_a <= {DATA_WIDTH{1'b0}};
            ex_data_alu_b <= {DATA_WIDTH{1'b0}};
            ex_addr_alu_a <= REG_ZERO;
            ex_addr_alu_b <= REG_ZERO;
            ex_imm        <= {DATA_WIDTH{1'b0}};
            ex_reg_addr   <= REG_ZERO;
            ex_reg_wr_ena <= 1'b0;
            ex_mem_rd_ena <= 1'b0;
            ex_mem_wr_ena <= 1'b0;
            ex_alu_op     <= {ALU_OP_WIDTH{1'b0}};
        end else begin
            ex_valid      <= 1'b1;
            ex_data_alu_a <= id_data_a;
            ex_data_alu_b <= id_data_b;
            ex_addr_alu_a <= id_addr_a;
            ex_addr_alu_b <= id_addr_b;
            ex_imm        <= id_imm;
            ex_reg_addr   <= id_reg_addr;
            // Writes to R0 are dropped here so the bypass mux never matches R0.
            ex_reg_wr_ena <= id_reg_wr_ena & (id_reg_addr != REG_ZERO);
            ex_mem_rd_ena <= id_mem_rd_ena;
            ex_mem_wr_ena <= id_mem_wr_ena;
            ex_alu_op     <= id_alu_op;
        end
    end

    // Saturating count of cycles lost to load-use bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= {CNT_WIDTH{1'b0}};
        end else if (count_stall_s && (lu_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            lu_stall_cnt <= lu_stall_cnt + CNT_WIDTH'(1);
        end else begin
            lu_stall_cnt <= lu_stall_cnt;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the EX slot. A second instance with a 3-bit counter
// exercises counter saturation within a short run.
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_data_a = 32'd0, id_data_b = 32'd0, id_imm = 32'd0;
    logic [4:0]  id_addr_a = 5'd0, id_addr_b = 5'd0, id_reg_addr = 5'd0;
    logic        id_rd_a_ena = 1'b0, id_rd_b_ena = 1'b0, id_reg_wr_ena = 1'b0;
    logic        id_mem_rd_ena = 1'b0, id_mem_wr_ena = 1'b0;
    logic [3:0]  id_alu_op = 4'd0;
    logic        flush = 1'b0, pipe_stall = 1'b0;

    logic        ex_valid, ex_reg_wr_ena, ex_mem_rd_ena, ex_mem_wr_ena, id_stall;
    logic [31:0] ex_data_alu_a, ex_data_alu_b, ex_imm;
    logic [4:0]  ex_addr_alu_a, ex_addr_alu_b, ex_reg_addr;
    logic [3:0]  ex_alu_op;
    logic [15:0] lu_stall_cnt;

    logic        sm_valid, sm_reg_wr_ena, sm_mem_rd_ena, sm_mem_wr_ena, sm_id_stall;
    logic [31:0] sm_data_a, sm_data_b, sm_imm;
    logic [4:0]  sm_addr_a, sm_addr_b, sm_reg_addr;
    logic [3:0]  sm_alu_op;
    logic [2:0]  sm_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the EX slot: what instruction sits there and how many stalls happened.
    logic        m_valid, m_we, m_mr, m_mw;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_aa, m_ab, m_rd;
    logic [3:0]  m_op;
    int          m_stalls;

    id_ex_hazard_reg dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_data_a(id_data_a), .id_data_b(id_data_b),
        .id_addr_a(id_addr_a), .id_addr_b(id_addr_b),
        .id_rd_a_ena(id_rd_a_ena), .id_rd_b_ena(id_rd_b_ena),
        .id_imm(id_imm), .id_reg_addr(id_reg_addr), .id_reg_wr_ena(id_reg_wr_ena),
        .id_mem_rd_ena(id_mem_rd_ena), .id_mem_wr_ena(id_mem_wr_ena),
        .id_alu_op(id_alu_op), .flush(flush), .pipe_stall(pipe_stall),
        .ex_valid(ex_valid), .ex_data_alu_a(ex_data_alu_a), .ex_data_alu_b(ex_data_alu_b),
        .ex_addr_alu_a(ex_addr_alu_a), .ex_addr_alu_b(ex_addr_alu_b), .ex_imm(ex_imm),
        .ex_reg_addr(ex_reg_addr), .ex_reg_wr_ena(ex_reg_wr_ena),
        .ex_mem_rd_ena(ex_mem_rd_ena), .ex_mem_wr_ena(ex_mem_wr_ena),
        .ex_alu_op(ex_alu_op), .id_stall(id_stall), .lu_stall_cnt(lu_stall_cnt)
    );

    id_ex_hazard_reg #(.CNT_WIDTH(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_data_a(id_data_a), .id_data_b(id_data_b),
        .id_addr_a(id_addr_a), .id_addr_b(id_addr_b),
        .id_rd_a_ena(id_rd_a_ena), .id_rd_b_ena(id_rd_b_ena),
        .id_imm(id_imm), .id_reg_addr(id_reg_addr), .id_reg_wr_ena(id_reg_wr_ena),
        .id_mem_rd_ena(id_mem_rd_ena), .id_mem_wr_ena(id_mem_wr_ena),
        .id_alu_op(id_alu_op), .flush(flush), .pipe_stall(pipe_stall),
        .ex_valid(sm_valid), .ex_data_alu_a(sm_data_a), .ex_data_alu_b(sm_data_b),
        .ex_addr_alu_a(sm_addr_a), .ex_addr_alu_b(sm_addr_b), .ex_imm(sm_imm),
        .ex_reg_addr(sm_reg_addr), .ex_reg_wr_ena(sm_reg_wr_ena),
        .ex_mem_rd_ena(sm_mem_rd_ena), .ex_mem_wr_ena(sm_mem_wr_ena),
        .ex_alu_op(sm_alu_op), .id_stall(sm_id_stall), .lu_stall_cnt(sm_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        logic ex_load;
        ex_load = m_valid && m_mr && m_we && (m_rd != 5'd0);
        return id_valid && ex_load &&
               ((id_rd_a_ena && id_addr_a == m_rd) || (id_rd_b_ena && id_addr_b == m_rd));
    endfunction

    function automatic logic model_id_stall();
        return pipe_stall || (!flush && model_hazard());
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_we = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        m_a = 32'd0; m_b = 32'd0; m_imm = 32'd0;
        m_aa = 5'd0; m_ab = 5'd0; m_rd = 5'd0; m_op = 4'd0;
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_step();
        logic haz;
        haz = model_hazard();
        if (pipe_stall) begin
            // EX contents and counter are frozen.
        end else if (flush || haz || !id_valid) begin
            if (!flush && haz) m_stalls++;
            model_clear();
        end else begin
            m_valid = 1'b1;
            m_a = id_data_a; m_b = id_data_b; m_imm = id_imm;
            m_aa = id_addr_a; m_ab = id_addr_b; m_rd = id_reg_addr; m_op = id_alu_op;
            m_we = id_reg_wr_ena && (id_reg_addr != 5'd0);
            m_mr = id_mem_rd_ena; m_mw = id_mem_wr_ena;
        end
    endtask

    task automatic compare_all();
        int big_exp;
        int small_exp;
        big_exp   = (m_stalls > 65535) ? 65535 : m_stalls;
        small_exp = (m_stalls > 7) ? 7 : m_stalls;
        chk("ex_valid",      32'(ex_valid),      32'(m_valid));
        chk("ex_data_alu_a", ex_data_alu_a,      m_a);
        chk("ex_data_alu_b", ex_data_alu_b,      m_b);
        chk("ex_addr_alu_a", 32'(ex_addr_alu_a), 32'(m_aa));
        chk("ex_addr_alu_b", 32'(ex_addr_alu_b), 32'(m_ab));
        chk("ex_imm",        ex_imm,             m_imm);
        chk("ex_reg_addr",   32'(ex_reg_addr),   32'(m_rd));
        chk("ex_reg_wr_ena", 32'(ex_reg_wr_ena), 32'(m_we));
        chk("ex_mem_rd_ena", 32'(ex_mem_rd_ena), 32'(m_mr));
        chk("ex_mem_wr_ena", 32'(ex_mem_wr_ena), 32'(m_mw));
        chk("ex_alu_op",     32'(ex_alu_op),     32'(m_op));
        chk("id_stall",      32'(id_stall),      32'(model_id_stall()));
        chk("lu_stall_cnt",  32'(lu_stall_cnt),  32'(big_exp));
        chk("small_cnt",     32'(sm_cnt),        32'(small_exp));
    endtask

    // Called just after a rising edge with inputs already set for the coming cycle.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Pulse reset in the middle of a cycle and check the asynchronous clear.
    task automatic pulse_reset();
        pipe_stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_data_a", ex_data_alu_a, 32'd0);
        chk("rst_ex_reg_addr", 32'(ex_reg_addr), 32'd0);
        chk("rst_ex_wr_ena", 32'(ex_reg_wr_ena), 32'd0);
        chk("rst_ex_mem_rd", 32'(ex_mem_rd_ena), 32'd0);
        chk("rst_cnt", 32'(lu_stall_cnt), 32'd0);
        chk("rst_id_stall", 32'(id_stall), 32'd0);
        model_clear();
        m_stalls = 0;
        pipe_stall = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_instr(input logic [4:0] aa, input logic rda, input logic [4:0] ab,
                             input logic rdb, input logic [4:0] rd, input logic we,
                             input logic mr, input logic mw);
        id_valid = 1'b1;
        id_addr_a = aa; id_rd_a_ena = rda; id_addr_b = ab; id_rd_b_ena = rdb;
        id_reg_addr = rd; id_reg_wr_ena = we; id_mem_rd_ena = mr; id_mem_wr_ena = mw;
        id_data_a = $urandom; id_data_b = $urandom; id_imm = $urandom;
        id_alu_op = 4'($urandom_range(0, 15));
        flush = 1'b0; pipe_stall = 1'b0;
    endtask

    task automatic drive_random();
        id_valid      = ($urandom_range(0, 9) != 0);
        id_data_a     = $urandom;
        id_data_b     = $urandom;
        id_imm        = $urandom;
        id_addr_a     = 5'($urandom_range(0, 3));
        id_addr_b     = 5'($urandom_range(0, 3));
        id_rd_a_ena   = 1'($urandom_range(0, 1));
        id_rd_b_ena   = 1'($urandom_range(0, 1));
        id_reg_addr   = 5'($urandom_range(0, 3));
        id_reg_wr_ena = ($urandom_range(0, 3) != 0);
        id_mem_rd_ena = 1'($urandom_range(0, 1));
        id_mem_wr_ena = 1'($urandom_range(0, 1));
        id_alu_op     = 4'($urandom_range(0, 15));
        flush         = ($urandom_range(0, 9) == 0);
        pipe_stall    = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        m_stalls = 0;
        model_clear();
        @(posedge clk);
        #1;
        pulse_reset();

        // Pass-through of a plain ALU instruction.
        set_instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        id_data_a = 32'h1234_5678;
        id_alu_op = 4'd2;
        cycle();
        chk("pt_valid", 32'(ex_valid), 32'd1);
        chk("pt_data_a", ex_data_alu_a, 32'h1234_5678);
        chk("pt_addr_a", 32'(ex_addr_alu_a), 32'd3);
        chk("pt_reg_addr", 32'(ex_reg_addr), 32'd7);
        chk("pt_wr_ena", 32'(ex_reg_wr_ena), 32'd1);
        chk("pt_alu_op", 32'(ex_alu_op), 32'd2);
        chk("pt_id_stall", 32'(id_stall), 32'd0);

        // LW r5 then ADD r6,r5,r1: exactly one bubble.
        set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cycle();
        set_instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_id_stall", 32'(id_stall), 32'd1);
        cycle();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_cnt", 32'(lu_stall_cnt), 32'd1);
        chk("lu_release", 32'(id_stall), 32'd0);
        cycle();
        chk("lu_dep_valid", 32'(ex_valid), 32'd1);
        chk("lu_dep_addr_a", 32'(ex_addr_alu_a), 32'd5);

        // LW r0 is captured without a write enable and never causes a stall.
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("r0_wr_ena", 32'(ex_reg_wr_ena), 32'd0);
        set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("r0_no_stall", 32'(id_stall), 32'd0);
        cycle();

        // Flush wins over a load-use hazard; global stall wins over flush.
        set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cycle();
        set_instr(5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        chk("fl_id_stall", 32'(id_stall), 32'd0);
        cycle();
        chk("fl_bubble", 32'(ex_valid), 32'd0);
        chk("fl_cnt", 32'(lu_stall_cnt), 32'd1);
        set_instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cycle();
        set_instr(5'd5, 1'b1, 5'd1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        pipe_stall = 1'b1;
        flush = 1'b1;
        #1;
        chk("ps_id_stall", 32'(id_stall), 32'd1);
        cycle();
        chk("ps_hold_valid", 32'(ex_valid), 32'd1);
        chk("ps_hold_rd", 32'(ex_reg_addr), 32'd5);
        chk("ps_hold_mr", 32'(ex_mem_rd_ena), 32'd1);
        chk("ps_cnt", 32'(lu_stall_cnt), 32'd1);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) pulse_reset();
            drive_random();
            cycle();
        end

        // Saturation of the narrow counter after nine load-use stalls.
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
            cycle();
            set_instr(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
            cycle();
        end
        chk("sat_small", 32'(sm_cnt), 32'd7);
        chk("sat_big", 32'(lu_stall_cnt), 32'd9);
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        cycle();
        set_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("sat_small_hold", 32'(sm_cnt), 32'd7);
        chk("sat_big_more", 32'(lu_stall_cnt), 32'd10);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the uDLX core, with integrated load-use hazard detection.
- Registers decoded operands, register addresses, immediate and control from decode, and presents them to the execute stage and its operand-bypass mux.
- Inserts a one-cycle bubble and holds fetch/decode when an instruction needs a register that a load currently in EX will write.
- Honours branch flush and global pipeline stall, and keeps a saturating count of load-use stall cycles.

Parameters:
- DATA_WIDTH, 32, operand/immediate width
- REG_ADDR_WIDTH, 5, register-file address width
- ALU_OP_WIDTH, 4, ALU opcode width
- CNT_WIDTH, 16, load-use stall counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_data_a  in  DATA_WIDTH  register-file read data, source A
- id_data_b  in  DATA_WIDTH  register-file read data, source B
- id_addr_a  in  REG_ADDR_WIDTH  source A register address
- id_addr_b  in  REG_ADDR_WIDTH  source B register address
- id_rd_a_ena  in  1  instruction actually reads source A
- id_rd_b_ena  in  1  instruction actually reads source B
- id_imm  in  DATA_WIDTH  sign/zero-extended immediate
- id_reg_addr  in  REG_ADDR_WIDTH  destination register
- id_reg_wr_ena  in  1  instruction writes destination
- id_mem_rd_ena  in  1  instruction is a load
- id_mem_wr_ena  in  1  instruction is a store
- id_alu_op  in  ALU_OP_WIDTH  ALU operation
- flush  in  1  branch/jump taken in EX; kill the decode slot
- pipe_stall  in  1  global stall (memory wait); freeze the register
- ex_valid  out  1  EX slot valid
- ex_data_alu_a  out  DATA_WIDTH  registered operand A
- ex_data_alu_b  out  DATA_WIDTH  registered operand B
- ex_addr_alu_a  out  REG_ADDR_WIDTH  registered source A address
- ex_addr_alu_b  out  REG_ADDR_WIDTH  registered source B address
- ex_imm  out  DATA_WIDTH  registered immediate
- ex_reg_addr  out  REG_ADDR_WIDTH  registered destination
- ex_reg_wr_ena  out  1  registered write enable
- ex_mem_rd_ena  out  1  registered load flag
- ex_mem_wr_ena  out  1  registered store flag
- ex_alu_op  out  ALU_OP_WIDTH  registered ALU op
- id_stall  out  1  combinational; hold PC and IF/ID register this cycle
- lu_stall_cnt  out  CNT_WIDTH  load-use stall cycles, saturating

Behaviour:
- Reset (rst_n low, asynchronous): every registered output goes to 0, including lu_stall_cnt. id_stall is 0 while in reset.
- Hazard term, combinational:
  lu_hazard = id_valid & ex_valid & ex_mem_rd_ena & ex_reg_wr_ena & (ex_reg_addr != 0) & ((id_rd_a_ena & id_addr_a == ex_reg_addr) | (id_rd_b_ena & id_addr_b == ex_reg_addr)).
- Per-cycle action, priority highest first:
  1. pipe_stall=1: all EX registers hold; id_stall=1; counter holds.
  2. flush=1: load a bubble; id_stall=0, because IF/ID is flushed upstream.
  3. lu_hazard=1: load a bubble; id_stall=1; lu_stall_cnt increments unless already all-ones.
  4. Otherwise: capture all id_* inputs; ex_valid=id_valid; id_stall=0.
- Bubble contents: ex_valid, ex_reg_wr_ena, ex_mem_rd_ena and ex_mem_wr_ena = 0. Data, address, imm and alu_op fields = 0.
- R0 rule: on a normal load, ex_reg_wr_ena = id_reg_wr_ena & id_valid & (id_reg_addr != 0). The bypass mux never sees a write enabled to R0.
- Latency: one cycle, ID to EX. A load-use pair costs exactly one bubble.
  - After the bubble, the load is in MEM and the dependent instruction re-evaluates.
  - lu_hazard is then 0 and the dependent instruction enters EX; the bypass path supplies the loaded value from WB.
- Store data dependency on a load (source B) stalls like any other read; there is no store-specific exemption.
- Counter: saturates at 2^CNT_WIDTH-1 and never wraps. It is not cleared except by reset.
- Reset asserted mid-stall: everything clears immediately. The first cycle after deassert behaves as the normal-load case.
- Invalid decode slot (id_valid=0): lu_hazard is forced 0, and the slot is loaded as a bubble-equivalent (ex_valid=0, enables 0).

Test Plan:
- Reset: drive random inputs and pulse rst_n low mid-cycle -> all ex_* outputs and lu_stall_cnt = 0 immediately, asynchronously; id_stall=0.
- Pass-through: id_data_a=0x12345678, id_addr_a=3, id_reg_addr=7, wr_ena=1, alu_op=2 -> next edge ex_* equal these values, ex_valid=1, id_stall=0.
- Load-use: LW r5 enters EX, then ADD r6,r5,r1 is in ID -> id_stall=1 for exactly 1 cycle, EX holds a bubble (ex_valid=0), lu_stall_cnt=1. The cycle after, the ADD is in EX with ex_addr_alu_a=5.
- R0 non-hazard: LW r0 in EX, ID reads r0 -> no stall. Also LW r0 captured -> ex_reg_wr_ena=0.
- Priority: flush=1 together with a load-use hazard -> bubble, id_stall=0, counter unchanged. pipe_stall=1 with flush=1 -> EX holds its previous contents, id_stall=1.
- Saturation: preload the counter to 0xFFFE and create 3 load-use stalls -> lu_stall_cnt reads 0xFFFF and stays there.
